alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have no parameters; datapath width is fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 operand1  input  16  first operand (A); sole operand for shift/load ops.
REQ-005 operand2  input  16  second operand (B); used by ALU group only.
REQ-006 carryIn  input  1  carry flag input for ADC/SBC/ROL/ROR and pass-through.
REQ-007 enableAlu  input  1  selects the arithmetic/logic group.
REQ-008 aluOperation  input  3  ALU group opcode.
REQ-009 enableShift  input  1  selects the shift/rotate group.
REQ-010 shiftOperation  input  3  shift group opcode.
REQ-011 enableLoad  input  1  selects the load/byte group.
REQ-012 loadOperation  input  3  load group opcode.
REQ-013 result  output  16  registered result.
REQ-014 carryOut  output  1  registered carry flag.

Function
REQ-015 result and carryOut SHALL be registered: inputs sampled at rising edge N appear at outputs after edge N, i.e. one-cycle latency, no handshake.
REQ-016 Group priority SHALL be enableAlu > enableShift > enableLoad; with none asserted, next result = operand1, next carryOut = carryIn.
REQ-017 ALU group: ADD(0) A+B, carry = bit 16 of the sum; ADC(1) A+B+carryIn, carry = bit 16.
REQ-018 ALU group: SUB(2) A+~B+1; SBC(3) A+~B+carryIn; carry = bit 16 (1 = no borrow).
REQ-019 ALU group: AND(4), OR(5), XOR(6) bitwise A op B; NOT(7) = ~A; all four SHALL clear carryOut to 0.
REQ-020 Shift group: SHL(0) {A[14:0],0}, carry=A[15]; SHR(1) {0,A[15:1]}, carry=A[0]; ASHR(2) {A[15],A[15:1]}, carry=A[0].
REQ-021 Shift group: ROL(3) {A[14:0],carryIn}, carry=A[15]; ROR(4) {carryIn,A[15:1]}, carry=A[0].
REQ-022 Shift opcodes 5-7 reserved: result = A, carryOut = carryIn.
REQ-023 Load group: COPY(0) A; SWAP(1) {A[7:0],A[15:8]}; LDL(2) {8'h00,A[7:0]}; LDH(3) {8'h00,A[15:8]}; all pass carryIn to carryOut.
REQ-024 Load opcodes 4-7 reserved: result = A, carryOut = carryIn.
REQ-025 Arithmetic SHALL wrap modulo 2^16; no overflow/zero/negative flags are produced.

Reset
REQ-026 While reset is high at a rising edge, result SHALL become 16'h0000 and carryOut 0, overriding all enables.
REQ-027 The first valid result SHALL appear one cycle after the first edge with reset low; reset mid-operation discards the pending result.

Structure
REQ-028 Opcode constants for all three groups (ADD_OP..NOT_OP, SHL_OP..ROR_OP, COPY_OP..LDH_OP) SHALL reside in a shared package used by the ALU and the decoder.
REQ-029 Combinational next-state logic SHALL be one sub-module alu_core (pure function of inputs), with alu holding only the output registers.

Verification
REQ-030 ADC A=000A B=000F cIn=1 -> result 001A, carry 0; ADD A=F000 B=1243 -> 0243, carry 1.
REQ-031 SHL A=8234 -> 0468 c1; ASHR A=8235 -> C11A c1; SHR A=8234 -> 411A c0.
REQ-032 ROL A=8235 cIn=1 -> 046B c1; ROR A=8235 cIn=0 -> 411A c1, cIn=1 -> C11A c1.
REQ-033 NOT A=8235 -> 7DCA c0; COPY/SWAP/LDL/LDH A=8235 cIn=1 -> 8235/3582/0035/0082, carry 1.
REQ-034 Priority and latency: enableAlu and enableLoad both high with ADD -> sum appears exactly one edge later; no enable -> result = operand1.
REQ-035 Reset asserted during a SUB stream -> result 0000, carry 0 on that edge; operation resumes one cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and helpers for the 16-bit ALU and its decoder.
// Every group's opcodes live here so the core and the bench agree on them.
package alu_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      ADD_OP = 3'd0,
      ADC_OP = 3'd1,
      SUB_OP = 3'd2,
      SBC_OP = 3'd3,
      AND_OP = 3'd4,
      OR_OP  = 3'd5,
      XOR_OP = 3'd6,
      NOT_OP = 3'd7
   } aluOp_t;

   typedef enum logic [2:0] {
      SHL_OP  = 3'd0,
      SHR_OP  = 3'd1,
      ASHR_OP = 3'd2,
      ROL_OP  = 3'd3,
      ROR_OP  = 3'd4
   } shiftOp_t;

   typedef enum logic [2:0] {
      COPY_OP = 3'd0,
      SWAP_OP = 3'd1,
      LDL_OP  = 3'd2,
      LDH_OP  = 3'd3
   } loadOp_t;

   // The top bit of the returned sum is the carry; subtraction passes ~B.
   function automatic logic [DATA_W:0] addCarry(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              cin);
      addCarry = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
   endfunction

endpackage

// File: rtl/alu_if.sv
// Operand, opcode and result bundle between the ALU and whoever drives it.
interface alu_if;
   import alu_pkg::*;

   logic [DATA_W-1:0] operand1;
   logic [DATA_W-1:0] operand2;
   logic              carryIn;
   logic              enableAlu;
   logic [2:0]        aluOperation;
   logic              enableShift;
   logic [2:0]        shiftOperation;
   logic              enableLoad;
   logic [2:0]        loadOperation;
   logic [DATA_W-1:0] result;
   logic              carryOut;

   modport master (
      output operand1, operand2, carryIn,
      output enableAlu, aluOperation,
      output enableShift, shiftOperation,
      output enableLoad, loadOperation,
      input  result, carryOut
   );

   modport slave (
      input  operand1, operand2, carryIn,
      input  enableAlu, aluOperation,
      input  enableShift, shiftOperation,
      input  enableLoad, loadOperation,
      output result, carryOut
   );

endinterface

// File: rtl/alu_core.sv
// Combinational decoder/datapath: computes the next result and carry from
// the current inputs, with group priority ALU > shift > load > pass-through.
module alu_core
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] i_operand1,
   input  logic [DATA_W-1:0] i_operand2,
   input  logic              i_carryIn,
   input  logic              i_enableAlu,
   input  logic [2:0]        i_aluOperation,
   input  logic              i_enableShift,
   input  logic [2:0]        i_shiftOperation,
   input  logic              i_enableLoad,
   input  logic [2:0]        i_loadOperation,
   output logic [DATA_W-1:0] o_nextResult,
   output logic              o_nextCarry
);

   logic [DATA_W:0] w_sum;

   // Reserved opcodes and the no-enable case fall back to A with carry passed through.
   always_comb begin
      o_nextResult = i_operand1;
      o_nextCarry  = i_carryIn;
      w_sum        = '0;
      if (i_enableAlu) begin
         case (i_aluOperation)
            ADD_OP: w_sum = addCarry(i_operand1, i_operand2, 1'b0);
            ADC_OP: w_sum = addCarry(i_operand1, i_operand2, i_carryIn);
            SUB_OP: w_sum = addCarry(i_operand1, ~i_operand2, 1'b1);
            SBC_OP: w_sum = addCarry(i_operand1, ~i_operand2, i_carryIn);
            default: w_sum = '0;
         endcase
         case (i_aluOperation)
            AND_OP: begin o_nextResult = i_operand1 & i_operand2; o_nextCarry = 1'b0; end
            OR_OP:  begin o_nextResult = i_operand1 | i_operand2; o_nextCarry = 1'b0; end
            XOR_OP: begin o_nextResult = i_operand1 ^ i_operand2; o_nextCarry = 1'b0; end
            NOT_OP: begin o_nextResult = ~i_operand1;             o_nextCarry = 1'b0; end
            default: begin
               o_nextResult = w_sum[DATA_W-1:0];
               o_nextCarry  = w_sum[DATA_W];
            end
         endcase
      end else if (i_enableShift) begin
         case (i_shiftOperation)
            SHL_OP:  begin o_nextResult = {i_operand1[14:0], 1'b0};          o_nextCarry = i_operand1[15]; end
            SHR_OP:  begin o_nextResult = {1'b0, i_operand1[15:1]};          o_nextCarry = i_operand1[0];  end
            ASHR_OP: begin o_nextResult = {i_operand1[15], i_operand1[15:1]}; o_nextCarry = i_operand1[0];  end
            ROL_OP:  begin o_nextResult = {i_operand1[14:0], i_carryIn};     o_nextCarry = i_operand1[15]; end
            ROR_OP:  begin o_nextResult = {i_carryIn, i_operand1[15:1]};     o_nextCarry = i_operand1[0];  end
            default: ;
         endcase
      end else if (i_enableLoad) begin
         case (i_loadOperation)
            COPY_OP: o_nextResult = i_operand1;
            SWAP_OP: o_nextResult = {i_operand1[7:0], i_operand1[15:8]};
            LDL_OP:  o_nextResult = {8'h00, i_operand1[7:0]};
            LDH_OP:  o_nextResult = {8'h00, i_operand1[15:8]};
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu.sv
// 16-bit ALU top: registers the core's next result/carry, giving one cycle
// of latency; a synchronous reset clears both outputs.
module alu
   import alu_pkg::*;
(
   input  logic clk,
   input  logic reset,
   alu_if.slave bus
);

   logic [DATA_W-1:0] w_nextResult;
   logic              w_nextCarry;
   logic [DATA_W-1:0] r_result;
   logic              r_carry;

   alu_core u_core (
      .i_operand1       (bus.operand1),
      .i_operand2       (bus.operand2),
      .i_carryIn        (bus.carryIn),
      .i_enableAlu      (bus.enableAlu),
      .i_aluOperation   (bus.aluOperation),
      .i_enableShift    (bus.enableShift),
      .i_shiftOperation (bus.shiftOperation),
      .i_enableLoad     (bus.enableLoad),
      .i_loadOperation  (bus.loadOperation),
      .o_nextResult     (w_nextResult),
      .o_nextCarry      (w_nextCarry)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_result <= '0;
         r_carry  <= 1'b0;
      end else begin
         r_result <= w_nextResult;
         r_carry  <= w_nextCarry;
      end
   end

   assign bus.result   = r_result;
   assign bus.carryOut = r_carry;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: a table of hand-computed vectors plus short
// sequences covering reset release, registering and reset mid-stream.
module tb_alu;
   import alu_pkg::*;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        enA;
      logic [2:0]  aOp;
      logic        enS;
      logic [2:0]  sOp;
      logic        enL;
      logic [2:0]  lOp;
      logic [15:0] expRes;
      logic        expC;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   alu_if bus();

   alu dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic addVec(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic enA, input logic [2:0] aOp,
                         input logic enS, input logic [2:0] sOp, input logic enL,
                         input logic [2:0] lOp, input logic [15:0] expRes, input logic expC);
      vec_t v;
      v.name = name; v.a = a; v.b = b; v.cin = cin;
      v.enA = enA; v.aOp = aOp; v.enS = enS; v.sOp = sOp; v.enL = enL; v.lOp = lOp;
      v.expRes = expRes; v.expC = expC;
      vecs.push_back(v);
   endtask

   task automatic driveInputs(input vec_t v);
      bus.operand1       = v.a;
      bus.operand2       = v.b;
      bus.carryIn        = v.cin;
      bus.enableAlu      = v.enA;
      bus.aluOperation   = v.aOp;
      bus.enableShift    = v.enS;
      bus.shiftOperation = v.sOp;
      bus.enableLoad     = v.enL;
      bus.loadOperation  = v.lOp;
   endtask

   // Drive after the falling edge, then sample 1ns past the next rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      driveInputs(v);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] expRes, input logic expC);
      checks++;
      if (bus.result !== expRes || bus.carryOut !== expC) begin
         errors++;
         $display("[TB] FAIL %s: got result=%h carry=%b, expected result=%h carry=%b",
                  name, bus.result, bus.carryOut, expRes, expC);
      end
   endtask

   function automatic vec_t mkAlu(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic [2:0] op);
      vec_t v;
      v.name = "alu"; v.a = a; v.b = b; v.cin = cin;
      v.enA = 1'b1; v.aOp = op; v.enS = 1'b0; v.sOp = 3'd0; v.enL = 1'b0; v.lOp = 3'd0;
      v.expRes = '0; v.expC = 1'b0;
      return v;
   endfunction

   initial begin
      addVec("ADC",        16'h000A, 16'h000F, 1'b1, 1, ADC_OP, 0, 0, 0, 0, 16'h001A, 1'b0);
      addVec("ADD",        16'hF000, 16'h1243, 1'b0, 1, ADD_OP, 0, 0, 0, 0, 16'h0243, 1'b1);
      addVec("ADDwrap",    16'hFFFF, 16'h0001, 1'b0, 1, ADD_OP, 0, 0, 0, 0, 16'h0000, 1'b1);
      addVec("SUBnoBorrow",16'h0005, 16'h0003, 1'b0, 1, SUB_OP, 0, 0, 0, 0, 16'h0002, 1'b1);
      addVec("SUBborrow",  16'h0003, 16'h0005, 1'b1, 1, SUB_OP, 0, 0, 0, 0, 16'hFFFE, 1'b0);
      addVec("SBC",        16'h0005, 16'h0003, 1'b0, 1, SBC_OP, 0, 0, 0, 0, 16'h0001, 1'b1);
      addVec("AND",        16'h8235, 16'h0F0F, 1'b1, 1, AND_OP, 0, 0, 0, 0, 16'h0205, 1'b0);
      addVec("OR",         16'h8235, 16'h0F0F, 1'b1, 1, OR_OP,  0, 0, 0, 0, 16'h8F3F, 1'b0);
      addVec("XOR",        16'h8235, 16'h0F0F, 1'b1, 1, XOR_OP, 0, 0, 0, 0, 16'h8D3A, 1'b0);
      addVec("NOT",        16'h8235, 16'h0000, 1'b1, 1, NOT_OP, 0, 0, 0, 0, 16'h7DCA, 1'b0);
      addVec("SHL",        16'h8234, 16'h0000, 1'b0, 0, 0, 1, SHL_OP,  0, 0, 16'h0468, 1'b1);
      addVec("ASHR",       16'h8235, 16'h0000, 1'b0, 0, 0, 1, ASHR_OP, 0, 0, 16'hC11A, 1'b1);
      addVec("SHR",        16'h8234, 16'h0000, 1'b1, 0, 0, 1, SHR_OP,  0, 0, 16'h411A, 1'b0);
      addVec("ROL",        16'h8235, 16'h0000, 1'b1, 0, 0, 1, ROL_OP,  0, 0, 16'h046B, 1'b1);
      addVec("RORc0",      16'h8235, 16'h0000, 1'b0, 0, 0, 1, ROR_OP,  0, 0, 16'h411A, 1'b1);
      addVec("RORc1",      16'h8235, 16'h0000, 1'b1, 0, 0, 1, ROR_OP,  0, 0, 16'hC11A, 1'b1);
      addVec("shiftRsvd",  16'h1234, 16'h0000, 1'b1, 0, 0, 1, 3'd5,    0, 0, 16'h1234, 1'b1);
      addVec("COPY",       16'h8235, 16'h0000, 1'b1, 0, 0, 0, 0, 1, COPY_OP, 16'h8235, 1'b1);
      addVec("SWAP",       16'h8235, 16'h0000, 1'b1, 0, 0, 0, 0, 1, SWAP_OP, 16'h3582, 1'b1);
      addVec("LDL",        16'h8235, 16'h0000, 1'b1, 0, 0, 0, 0, 1, LDL_OP,  16'h0035, 1'b1);
      addVec("LDH",        16'h8235, 16'h0000, 1'b1, 0, 0, 0, 0, 1, LDH_OP,  16'h0082, 1'b1);
      addVec("loadRsvd",   16'hABCD, 16'h0000, 1'b0, 0, 0, 0, 0, 1, 3'd6,    16'hABCD, 1'b0);
      addVec("noEnable",   16'h5A5A, 16'h1111, 1'b1, 0, 0, 0, 0, 0, 0,       16'h5A5A, 1'b1);
      addVec("aluOverLoad",16'h1111, 16'h2222, 1'b0, 1, ADD_OP, 0, 0, 1, SWAP_OP, 16'h3333, 1'b0);
      addVec("shiftOverLd",16'h0001, 16'h0000, 1'b0, 0, 0, 1, SHL_OP, 1, COPY_OP, 16'h0002, 1'b0);

      // Reset overrides an enabled ADD, then the first result follows release.
      driveInputs(mkAlu(16'h1111, 16'h2222, 1'b1, ADD_OP));
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("resetHold", 16'h0000, 1'b0);
      @(posedge clk); #1;
      checkOutput("resetHold2", 16'h0000, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("preRelease", 16'h0000, 1'b0);
      @(posedge clk); #1;
      checkOutput("firstResult", 16'h3333, 1'b0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i].name, vecs[i].expRes, vecs[i].expC);
      end

      // SUB stream: result holds until the next edge, reset wipes it, then resumes.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(mkAlu(16'h0100, 16'(i + 1), 1'b0, SUB_OP));
         checkOutput("subStream", 16'h0100 - 16'(i + 1), 1'b1);
      end
      @(negedge clk);
      driveInputs(mkAlu(16'h0200, 16'h0001, 1'b0, SUB_OP));
      #1;
      checkOutput("holdBeforeEdge", 16'h00FD, 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("midReset", 16'h0000, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("resume", 16'h01FF, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
